uart_report_rx: RTL and testbench
=================================

Name: uart_report_rx

Overview:
Serial receiver and line parser that consumes the MVP UART stream (8N1, LSB first), the output of the UART MVP top. Decodes the header, CFG and periodic report lines ("IN=XXXXXXXX EM=XXXXXXXX FT=XXXXXXXX IV=XXXXXXXX ST=XXXXXXXX" CR LF). Presents the five 32-bit counters as a validated snapshot. Used as a self-checking monitor in simulation and as a loopback checker on hardware.

Parameters:
CLKS_PER_BIT, 16, clocks per UART bit; must be even and >= 8
MAX_LINE, 64, maximum bytes per line including CR LF before overflow error

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
rx_i  in  1  serial input; idle high
byte_valid  out  1  one-cycle pulse per good byte (debug)
byte_data  out  8  received byte; valid with byte_valid
rep_valid  out  1  one-cycle pulse when a complete report line commits
rep_in, rep_em, rep_ft, rep_iv, rep_st  out  32 each  last committed counter snapshot
hdr_seen  out  1  sticky; set by an exact header line
cfg_seen  out  1  sticky; set by a well-formed CFG line
err_frame  out  1  one-cycle pulse on a stop-bit error
err_parse  out  1  one-cycle pulse on a line format error
cnt_lines_ok  out  16  good report lines; saturates at 16'hFFFF
cnt_errors  out  16  frame plus parse errors; saturates at 16'hFFFF

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to 1. Both FSMs go to their idle states. Reset asserted mid-byte or mid-line discards the partial data; no pulse is generated.
- rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised low.
  - START: count CLKS_PER_BIT/2-1 cycles, then resample. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit). 8 samples, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, byte_valid/byte_data are asserted the next cycle. If 0, err_frame pulses the next cycle and the byte is dropped.
  - STOP returns to IDLE right after the stop-bit sample, so a start bit arriving half a bit later is caught.
- Parser FSM states: P_START, P_REP, P_HDR, P_CFG, P_SKIP. It advances only on good bytes and keeps a byte index, idx.
  - P_START, first byte: 'I' -> P_REP; 'A' -> P_HDR; 'C' -> P_CFG; LF -> stay in P_START; any other byte -> err_parse, P_SKIP.
  - P_REP: every position is checked against the 61-byte template.
    - Hex positions 3-10, 15-22, 27-34, 39-46 and 51-58 accept only '0'-'9' and 'A'-'F' (uppercase). Each accepted digit shifts 4 bits into that field's shadow register, MSB nibble first.
    - Byte 59 must be CR and byte 60 must be LF.
    - On LF at idx 60, all five shadows copy to rep_* in the same cycle, and rep_valid pulses one cycle after the LF byte_valid. cnt_lines_ok increments.
  - P_HDR: exact match of "ATOMiK UART MVP" CR LF (17 bytes). Sets hdr_seen on LF.
  - P_CFG: bytes 0-3 must be "CFG ". After that, any byte 0x20-0x7E is accepted until CR then LF. Sets cfg_seen on LF.
  - Any mismatch in P_REP, P_HDR or P_CFG: err_parse pulses once, go to P_SKIP.
  - Line overflow (idx reaching MAX_LINE without LF): err_parse pulses once, go to P_SKIP.
  - P_SKIP discards bytes until LF, then goes to P_START.
- A frame error while a line is in progress forces P_SKIP without an err_parse pulse. It counts once in cnt_errors.
- rep_* hold their values until the next good report. A bad line never modifies rep_*; only the shadows change.
- err_frame and err_parse in the same cycle: cnt_errors increments by 2, saturating.

Decomposition:
- Shared package holds the ASCII constants (CR 8'h0D, LF 8'h0A, SP) and the line-length constants: HDR_LEN 17, CFG_LEN 31, REP_LEN 61, hex field start offsets 3/15/27/39/51.
- The same package holds the hex-char-to-nibble function plus an is_hex flag.
- One sub-module, uart_rx (synchroniser plus bit FSM, byte_valid/byte_data/err_frame out). This block instantiates it and adds the parser.

Test Plan:
- Bench UART driver sends the header, then "CFG DEPTH=625 CPB=16 RC=20000" CR LF, at CPB=16 -> hdr_seen=1, cfg_seen=1, no error pulses, rep_valid=0.
- Send "IN=0000002A EM=00000029 FT=00000010 IV=00000001 ST=00000000" CR LF -> one rep_valid, 1 cycle after the LF byte_valid. rep_in=32'h2A, rep_em=32'h29, rep_ft=32'h10, rep_iv=1, rep_st=0. cnt_lines_ok=1.
- Same line with a lowercase 'a' at byte 10 -> err_parse at byte 10, no rep_valid, rep_* unchanged. The next valid line commits normally.
- Stop bit forced 0 mid-report -> err_frame pulse, line skipped, cnt_errors=1. The following good line commits.
- 4-clock low glitch on idle rx_i -> no byte_valid, no error. 70 bytes without LF -> err_parse at byte 64, then recovery at LF.
- rst_n asserted during byte 30 of a report -> all outputs 0 immediately. The bench then sends a full line after release -> it parses correctly.

Source files
------------

// File: rtl/uart_report_rx_pkg.sv
// Shared constants and character helpers for the UART report receiver and its line parser.
package uart_report_rx_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  localparam int unsigned HDR_LEN    = 17;
  localparam int unsigned CFG_LEN    = 31;
  localparam int unsigned REP_LEN    = 61;
  localparam int unsigned HEX_IN     = 3;
  localparam int unsigned HEX_EM     = 15;
  localparam int unsigned HEX_FT     = 27;
  localparam int unsigned HEX_IV     = 39;
  localparam int unsigned HEX_ST     = 51;
  localparam int unsigned HEX_DIGITS = 8;
  localparam logic [2:0]  NO_FIELD   = 3'd7;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {PStart, PRep, PHdr, PCfg, PSkip} parse_state_e;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
  endfunction

  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    return (c <= "9") ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  // Which counter field a report position feeds; NO_FIELD for fixed template bytes.
  function automatic logic [2:0] rep_field(input int unsigned i);
    if (i >= HEX_IN && i < HEX_IN + HEX_DIGITS) return 3'd0;
    if (i >= HEX_EM && i < HEX_EM + HEX_DIGITS) return 3'd1;
    if (i >= HEX_FT && i < HEX_FT + HEX_DIGITS) return 3'd2;
    if (i >= HEX_IV && i < HEX_IV + HEX_DIGITS) return 3'd3;
    if (i >= HEX_ST && i < HEX_ST + HEX_DIGITS) return 3'd4;
    return NO_FIELD;
  endfunction

  function automatic logic [7:0] rep_char(input int unsigned i);
    case (i)
      0: return "I";   1: return "N";   2: return "=";
      11: return SP;   12: return "E";  13: return "M";  14: return "=";
      23: return SP;   24: return "F";  25: return "T";  26: return "=";
      35: return SP;   36: return "I";  37: return "V";  38: return "=";
      47: return SP;   48: return "S";  49: return "T";  50: return "=";
      59: return CR;   60: return LF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hdr_char(input int unsigned i);
    case (i)
      0: return "A";   1: return "T";   2: return "O";   3: return "M";
      4: return "i";   5: return "K";   6: return SP;    7: return "U";
      8: return "A";   9: return "R";   10: return "T";  11: return SP;
      12: return "M";  13: return "V";  14: return "P";  15: return CR;
      16: return LF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] cfg_char(input int unsigned i);
    case (i)
      0: return "C";   1: return "F";   2: return "G";
      default: return SP;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, registered byte and frame-error pulses.
module uart_rx
  import uart_report_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       err_frame_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q, err_frame_q;
  logic [7:0]      byte_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RxIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      err_frame_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      err_frame_q  <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          cnt_q <= '0;
          if (!rx_sync_q) state_q <= RxStart;
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            // Back to idle straight after the stop sample so an early next start is caught.
            cnt_q        <= '0;
            state_q      <= RxIdle;
            byte_valid_q <= rx_sync_q;
            err_frame_q  <= !rx_sync_q;
            if (rx_sync_q) byte_data_q <= shift_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign err_frame_o  = err_frame_q;

endmodule

// File: rtl/uart_report_rx.sv
// UART report monitor: parses header, CFG and counter report lines into a committed snapshot.
module uart_report_rx
  import uart_report_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MAX_LINE     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        rep_valid,
  output logic [31:0] rep_in,
  output logic [31:0] rep_em,
  output logic [31:0] rep_ft,
  output logic [31:0] rep_iv,
  output logic [31:0] rep_st,
  output logic        hdr_seen,
  output logic        cfg_seen,
  output logic        err_frame,
  output logic        err_parse,
  output logic [15:0] cnt_lines_ok,
  output logic [15:0] cnt_errors
);

  localparam int unsigned IdxW = $clog2(MAX_LINE + 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(MAX_LINE);

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .err_frame_o (err_frame)
  );

  parse_state_e    ps_q;
  logic [IdxW-1:0] idx_q;
  logic            cr_q;
  logic [31:0]     shadow_q [5];
  logic [31:0]     rep_q    [5];
  logic            rep_valid_q, err_parse_q, hdr_seen_q, cfg_seen_q;
  logic [15:0]     lines_q, errors_q;

  logic [31:0] idx_w;
  logic [2:0]  rep_fld;
  logic        byte_bad, line_done;
  logic [16:0] err_sum;

  assign idx_w = 32'(idx_q);

  // Judges the current byte against the line type in progress.
  always_comb begin
    rep_fld   = rep_field(idx_w);
    byte_bad  = (idx_q == IdxMax);
    line_done = 1'b0;
    case (ps_q)
      PRep: begin
        byte_bad  |= (rep_fld == NO_FIELD) ? (byte_data != rep_char(idx_w)) : !is_hex(byte_data);
        line_done = (idx_w == REP_LEN - 1);
      end
      PHdr: begin
        byte_bad  |= (byte_data != hdr_char(idx_w));
        line_done = (idx_w == HDR_LEN - 1);
      end
      PCfg: begin
        if (idx_w < 4) begin
          byte_bad |= (byte_data != cfg_char(idx_w));
        end else if (cr_q) begin
          byte_bad  |= (byte_data != LF);
          line_done = 1'b1;
        end else begin
          byte_bad |= !((byte_data >= 8'h20 && byte_data <= 8'h7E) || byte_data == CR);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q        <= PStart;
      idx_q       <= '0;
      cr_q        <= 1'b0;
      rep_valid_q <= 1'b0;
      err_parse_q <= 1'b0;
      hdr_seen_q  <= 1'b0;
      cfg_seen_q  <= 1'b0;
      lines_q     <= '0;
      for (int k = 0; k < 5; k++) begin
        shadow_q[k] <= '0;
        rep_q[k]    <= '0;
      end
    end else begin
      rep_valid_q <= 1'b0;
      err_parse_q <= 1'b0;
      if (err_frame && (ps_q == PRep || ps_q == PHdr || ps_q == PCfg)) begin
        ps_q <= PSkip;
      end else if (byte_valid) begin
        if (idx_q != IdxMax) idx_q <= idx_q + 1'b1;
        case (ps_q)
          PStart: begin
            idx_q <= IdxW'(1);
            cr_q  <= 1'b0;
            case (byte_data)
              "I":     ps_q <= PRep;
              "A":     ps_q <= PHdr;
              "C":     ps_q <= PCfg;
              LF:      idx_q <= '0;
              default: begin
                err_parse_q <= 1'b1;
                ps_q        <= PSkip;
              end
            endcase
          end
          PRep, PHdr, PCfg: begin
            if (byte_bad) begin
              // A bad LF still ends the line, so the next line is parsed rather than skipped.
              err_parse_q <= 1'b1;
              idx_q       <= '0;
              ps_q        <= (byte_data == LF) ? PStart : PSkip;
            end else if (line_done) begin
              idx_q <= '0;
              ps_q  <= PStart;
              if (ps_q == PRep) begin
                rep_q       <= shadow_q;
                rep_valid_q <= 1'b1;
                if (lines_q != 16'hFFFF) lines_q <= lines_q + 1'b1;
              end
              if (ps_q == PHdr) hdr_seen_q <= 1'b1;
              if (ps_q == PCfg) cfg_seen_q <= 1'b1;
            end else begin
              if (ps_q == PRep && rep_fld != NO_FIELD) begin
                shadow_q[rep_fld] <= {shadow_q[rep_fld][27:0], hex_nibble(byte_data)};
              end
              if (ps_q == PCfg && byte_data == CR) cr_q <= 1'b1;
            end
          end
          default: begin
            if (byte_data == LF) begin
              idx_q <= '0;
              ps_q  <= PStart;
            end
          end
        endcase
      end
    end
  end

  assign err_sum = {1'b0, errors_q} + 17'(err_frame) + 17'(err_parse_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errors_q <= '0;
    else        errors_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign rep_valid    = rep_valid_q;
  assign rep_in       = rep_q[0];
  assign rep_em       = rep_q[1];
  assign rep_ft       = rep_q[2];
  assign rep_iv       = rep_q[3];
  assign rep_st       = rep_q[4];
  assign hdr_seen     = hdr_seen_q;
  assign cfg_seen     = cfg_seen_q;
  assign err_parse    = err_parse_q;
  assign cnt_lines_ok = lines_q;
  assign cnt_errors   = errors_q;

endmodule

// File: tb/tb_uart_report_rx.sv
// Directed bench for uart_report_rx: UART line driver plus a report scoreboard.
module tb_uart_report_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_i = 1'b1;
  logic        byte_valid, rep_valid, hdr_seen, cfg_seen, err_frame, err_parse;
  logic [7:0]  byte_data;
  logic [31:0] rep_in, rep_em, rep_ft, rep_iv, rep_st;
  logic [15:0] cnt_lines_ok, cnt_errors;

  always #5 clk = ~clk;

  uart_report_rx #(.CLKS_PER_BIT(CPB), .MAX_LINE(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .rep_valid   (rep_valid),
    .rep_in      (rep_in),
    .rep_em      (rep_em),
    .rep_ft      (rep_ft),
    .rep_iv      (rep_iv),
    .rep_st      (rep_st),
    .hdr_seen    (hdr_seen),
    .cfg_seen    (cfg_seen),
    .err_frame   (err_frame),
    .err_parse   (err_parse),
    .cnt_lines_ok(cnt_lines_ok),
    .cnt_errors  (cnt_errors)
  );

  typedef struct packed {
    logic [31:0] in_v, em_v, ft_v, iv_v, st_v;
  } rep_t;

  rep_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   nbytes = 0, n_rep = 0, n_perr = 0, n_ferr = 0, perr_at = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: event counters and scoreboard pop on every committed report.
  initial begin
    logic       prev_bv;
    logic [7:0] prev_bd;
    rep_t       e;
    prev_bv = 1'b0;
    prev_bd = 8'h00;
    forever begin
      @(negedge clk);
      if (byte_valid) nbytes++;
      if (err_parse) begin
        n_perr++;
        perr_at = nbytes;
      end
      if (err_frame) n_ferr++;
      if (rep_valid) begin
        n_rep++;
        check("rep_after_lf", 32'({prev_bv, prev_bd}), 32'({1'b1, 8'h0A}));
        check("rep_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rep_in", rep_in, e.in_v);
          check("rep_em", rep_em, e.em_v);
          check("rep_ft", rep_ft, e.ft_v);
          check("rep_iv", rep_iv, e.iv_v);
          check("rep_st", rep_st, e.st_v);
        end
      end
      prev_bv = byte_valid;
      prev_bd = byte_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bit_time(input logic v);
    rx_i = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_crlf();
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  function automatic string hex8(input logic [31:0] v);
    string d = "0123456789ABCDEF";
    string r = "";
    for (int i = 7; i >= 0; i--) r = $sformatf("%s%c", r, d[v[4*i +: 4]]);
    return r;
  endfunction

  function automatic string rep_line(input rep_t r);
    return $sformatf("IN=%s EM=%s FT=%s IV=%s ST=%s",
                     hex8(r.in_v), hex8(r.em_v), hex8(r.ft_v), hex8(r.iv_v), hex8(r.st_v));
  endfunction

  task automatic send_rep(input rep_t r);
    exp_q.push_back(r);
    send_str(rep_line(r));
    send_crlf();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rep_t  r1, r2, r3, r5;
    string line;
    int    base;
    r1 = '{32'h0000002A, 32'h00000029, 32'h00000010, 32'h00000001, 32'h00000000};
    r2 = '{32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'hCAFEF00D};
    r3 = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005};
    r5 = '{32'h89ABCDEF, 32'h00C0FFEE, 32'h0000FFFF, 32'h10000000, 32'h7FFFFFFF};

    repeat (5) @(negedge clk);
    check("reset_flags", 32'({byte_valid, rep_valid, hdr_seen, cfg_seen, err_frame, err_parse}),
          32'd0);
    check("reset_rep_in", rep_in, 32'd0);
    check("reset_counts", {cnt_lines_ok, cnt_errors}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Header and CFG lines.
    send_str("ATOMiK UART MVP");
    send_crlf();
    send_str("CFG DEPTH=625 CPB=16 RC=20000");
    send_crlf();
    repeat (5) @(negedge clk);
    check("hdr_seen", 32'(hdr_seen), 32'd1);
    check("cfg_seen", 32'(cfg_seen), 32'd1);
    check("errs_after_hdr_cfg", 32'(n_perr + n_ferr), 32'd0);
    check("no_rep_after_hdr_cfg", 32'(n_rep), 32'd0);

    send_rep(r1);
    wait_drain();
    check("lines_ok_1", 32'(cnt_lines_ok), 32'd1);

    // Lowercase hex digit at byte 10.
    line = rep_line(r1);
    line[10] = "a";
    base = nbytes;
    send_str(line.substr(0, 10));
    send_crlf();
    repeat (5) @(negedge clk);
    check("lower_perr_count", 32'(n_perr), 32'd1);
    check("lower_perr_byte", 32'(perr_at), 32'(base + 11));
    check("lower_no_rep", 32'(n_rep), 32'd1);
    check("lower_rep_in_kept", rep_in, 32'h0000002A);
    check("lower_cnt_errors", 32'(cnt_errors), 32'd1);
    send_rep(r2);
    wait_drain();
    check("lines_ok_2", 32'(cnt_lines_ok), 32'd2);

    // Stop bit forced low on byte 20 of a report.
    line = rep_line(r3);
    for (int i = 0; i < 20; i++) send_byte(line[i], 1'b1);
    send_byte(line[20], 1'b0);
    repeat (12) bit_time(1'b1);
    send_byte(8'h0A, 1'b1);
    repeat (5) @(negedge clk);
    check("frame_ferr_count", 32'(n_ferr), 32'd1);
    check("frame_no_perr", 32'(n_perr), 32'd1);
    check("frame_cnt_errors", 32'(cnt_errors), 32'd2);
    check("frame_rep_in_kept", rep_in, 32'hDEADBEEF);
    send_rep(r3);
    wait_drain();
    check("lines_ok_3", 32'(cnt_lines_ok), 32'd3);

    // Short low glitch on the idle line.
    base = nbytes;
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_byte", 32'(nbytes), 32'(base));
    check("glitch_no_err", 32'(n_ferr + n_perr), 32'd2);

    // 70 bytes without LF overflows at byte 64.
    base = nbytes;
    send_str("CFG ");
    for (int i = 0; i < 66; i++) send_byte("X", 1'b1);
    repeat (5) @(negedge clk);
    check("ovf_perr_count", 32'(n_perr), 32'd2);
    check("ovf_perr_byte", 32'(perr_at), 32'(base + 65));
    send_byte(8'h0A, 1'b1);
    base = nbytes;
    send_byte("Z", 1'b1);
    send_byte(8'h0A, 1'b1);
    repeat (5) @(negedge clk);
    check("recover_perr_count", 32'(n_perr), 32'd3);
    check("recover_perr_byte", 32'(perr_at), 32'(base + 1));
    check("recover_cnt_errors", 32'(cnt_errors), 32'd4);

    // Reset in the middle of byte 30 of a report.
    line = rep_line(r5);
    send_str(line.substr(0, 29));
    bit_time(1'b0);
    bit_time(1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_flags",
          32'({byte_valid, rep_valid, hdr_seen, cfg_seen, err_frame, err_parse}), 32'd0);
    check("midreset_rep_in", rep_in, 32'd0);
    check("midreset_rep_st", rep_st, 32'd0);
    check("midreset_counts", {cnt_lines_ok, cnt_errors}, 32'd0);
    rx_i = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_rep(r5);
    wait_drain();
    check("post_reset_lines_ok", 32'(cnt_lines_ok), 32'd1);
    check("post_reset_cnt_errors", 32'(cnt_errors), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
